// File: rtl/step_dir_decoder.sv
// Step/dir receiver: synchronizes and deglitches the pins, tracks a signed position and exposes it on a register port.
// Optional step-period measurement is built when STEP_DIR_DECODER_PERIOD_EN is defined.
module step_dir_decoder #(
  parameter int POS_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int DIR_SETUP   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        step_in,
  input  logic        dir_in,
  output logic        step_pulse
);

  localparam int FW = $clog2(MIN_PULSE + 1);
  localparam int SW = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
  localparam logic [FW-1:0] FILT_ACC  = FW'(MIN_PULSE - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(MIN_PULSE);
  localparam logic [SW-1:0] SETUP_MAX = SW'(DIR_SETUP);

  logic [SYNC_STAGES-1:0]        r_step_sync, r_dir_sync, r_sync_vld;
  logic                          r_dir_d, r_armed;
  logic [FW-1:0]                 r_filt;
  logic [SW-1:0]                 r_setup;
  logic signed [POS_WIDTH-1:0]   r_pos;
  logic [31:0]                   r_total;
  logic                          r_last_dir, r_setup_err;

  logic        w_step, w_dir, w_vld, w_dir_chg, w_accept, w_setup_bad;
  logic        w_wr_pos, w_wr_stat, w_stall;
  logic [31:0] w_period, w_status;

  function automatic logic signed [POS_WIDTH-1:0] next_pos(
    input logic signed [POS_WIDTH-1:0] p, input logic up);
    return up ? p + $signed(POS_WIDTH'(1)) : p - $signed(POS_WIDTH'(1));
  endfunction

  assign w_step      = r_step_sync[SYNC_STAGES-1];
  assign w_dir       = r_dir_sync[SYNC_STAGES-1];
  assign w_vld       = r_sync_vld[SYNC_STAGES-1];
  assign w_dir_chg   = w_dir ^ r_dir_d;
  // r_armed blocks a pin that was already high when reset released
  assign w_accept    = r_armed & w_step & (r_filt == FILT_ACC);
  assign w_setup_bad = w_dir_chg | (r_setup < SETUP_MAX);
  assign w_wr_pos    = write & (address == 2'd0);
  assign w_wr_stat   = write & (address == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_sync <= '0;
      r_dir_sync  <= '0;
      r_sync_vld  <= '0;
      r_dir_d     <= 1'b0;
      r_armed     <= 1'b0;
      r_filt      <= '0;
      r_setup     <= SETUP_MAX;
    end else begin
      r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step_in};
      r_dir_sync  <= {r_dir_sync[SYNC_STAGES-2:0], dir_in};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_dir_d     <= w_dir;
      if (w_vld && !w_step)
        r_armed <= 1'b1;
      if (!w_step)
        r_filt <= '0;
      else if (r_filt != FILT_MAX)
        r_filt <= r_filt + FW'(1);
      if (w_dir_chg)
        r_setup <= '0;
      else if (r_setup != SETUP_MAX)
        r_setup <= r_setup + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos       <= '0;
      r_total     <= '0;
      r_last_dir  <= 1'b0;
      r_setup_err <= 1'b0;
      step_pulse  <= 1'b0;
    end else begin
      step_pulse <= w_accept;
      // a preset overrides a coincident step; the step still reaches the total
      if (w_wr_pos)
        r_pos <= writedata[POS_WIDTH-1:0];
      else if (w_accept)
        r_pos <= next_pos(r_pos, w_dir);
      if (w_accept) begin
        r_total    <= r_total + 32'd1;
        r_last_dir <= w_dir;
      end
      if (w_accept && w_setup_bad)
        r_setup_err <= 1'b1;
      else if (w_wr_stat && writedata[1])
        r_setup_err <= 1'b0;
    end
  end

`ifdef STEP_DIR_DECODER_PERIOD_EN
  logic [31:0] r_per_cnt, r_period;
  logic        r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_per_cnt <= '0;
      r_period  <= '0;
      r_stall   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_period  <= r_per_cnt;
        r_per_cnt <= 32'd1;
      end else if (r_per_cnt == 32'hFFFF_FFFF) begin
        r_period <= 32'hFFFF_FFFF;
      end else begin
        r_per_cnt <= r_per_cnt + 32'd1;
      end
      if (!w_accept && r_per_cnt == 32'hFFFF_FFFF)
        r_stall <= 1'b1;
      else if (w_wr_stat && writedata[2])
        r_stall <= 1'b0;
    end
  end

  assign w_period = r_period;
  assign w_stall  = r_stall;
`else
  assign w_period = 32'd0;
  assign w_stall  = 1'b0;
`endif

  assign w_status = {29'd0, w_stall, r_setup_err, r_last_dir};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      case (address)
        2'd0:    readdata <= 32'(r_pos);
        2'd1:    readdata <= w_period;
        2'd2:    readdata <= w_status;
        default: readdata <= r_total;
      endcase
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: table of pulse vectors plus hand-written corner sequences.
module tb_step_dir_decoder;
  logic        clk = 1'b0;
  logic        reset, write, read, step_in, dir_in, step_pulse;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  step_dir_decoder dut (
    .clk(clk), .reset(reset), .write(write), .address(address),
    .writedata(writedata), .read(read), .readdata(readdata),
    .step_in(step_in), .dir_in(dir_in), .step_pulse(step_pulse)
  );

  typedef struct {
    logic d;
    int   gap;
    int   hi;
    logic acc;
    logic err;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); read = 1'b1; address = a;
    @(negedge clk); read = 1'b0; d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] dat);
    @(negedge clk); write = 1'b1; address = a; writedata = dat;
    @(negedge clk); write = 1'b0;
  endtask

  task automatic do_pulse(input logic d, input int gap, input int hi, input int lo,
                          output int n, output int idx);
    n = 0; idx = -1;
    @(negedge clk); dir_in = d;
    repeat (gap) @(negedge clk);
    step_in = 1'b1;
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge clk);
      if (step_pulse) begin
        n++;
        if (idx < 0) idx = i;
      end
      if (i == hi - 1) step_in = 1'b0;
    end
  endtask

  initial begin
    logic [31:0]        d;
    logic signed [31:0] m_pos;
    logic [31:0]        m_tot;
    logic               m_dir, m_err;
    int                 n, idx, seen;

    reset = 1'b1; write = 1'b0; read = 1'b0; step_in = 1'b0; dir_in = 1'b0;
    address = 2'd0; writedata = 32'd0;
    vt[0] = '{d: 1'b1, gap: 3, hi: 1, acc: 1'b0, err: 1'b0};
    vt[1] = '{d: 1'b1, gap: 3, hi: 1, acc: 1'b0, err: 1'b0};
    vt[2] = '{d: 1'b1, gap: 3, hi: 2, acc: 1'b1, err: 1'b0};
    vt[3] = '{d: 1'b0, gap: 3, hi: 3, acc: 1'b1, err: 1'b0};
    vt[4] = '{d: 1'b1, gap: 1, hi: 4, acc: 1'b1, err: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_pulse", {31'd0, step_pulse}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("rst_reg%0d", a), d, 32'd0);
    end

    for (int k = 0; k < 10; k++) begin
      do_pulse(1'b1, 3, 4, 4, n, idx);
      check("up_pulses", n, 32'd1);
      check("up_latency", idx, 32'd3);
    end
    rd(2'd0, d); check("pos_10", d, 32'd10);
    rd(2'd3, d); check("tot_10", d, 32'd10);

    for (int k = 0; k < 20; k++) begin
      do_pulse(1'b0, 3, 4, 4, n, idx);
      check("dn_pulses", n, 32'd1);
    end
    rd(2'd0, d); check("pos_m10", d, 32'hFFFF_FFF6);
    rd(2'd3, d); check("tot_30", d, 32'd30);
    rd(2'd2, d); check("stat_dn", d, 32'd0);

    m_pos = -32'sd10; m_tot = 32'd30; m_dir = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_pulse(vt[k].d, vt[k].gap, vt[k].hi, 4, n, idx);
      check($sformatf("vec%0d_pulses", k), n, {31'd0, vt[k].acc});
      if (vt[k].acc) begin
        check($sformatf("vec%0d_latency", k), idx, 32'd3);
        m_pos = vt[k].d ? m_pos + 32'sd1 : m_pos - 32'sd1;
        m_tot = m_tot + 32'd1;
        m_dir = vt[k].d;
      end
      if (vt[k].err) m_err = 1'b1;
      rd(2'd0, d); check($sformatf("vec%0d_pos", k), d, m_pos);
      rd(2'd2, d); check($sformatf("vec%0d_stat", k), d, {30'd0, m_err, m_dir});
    end
    rd(2'd3, d); check("tot_vec", d, m_tot);

    wr(2'd2, 32'h2);
    rd(2'd2, d); check("stat_clr", d, 32'h1);

    wr(2'd0, 32'h7FFF_FFFF);
    rd(2'd0, d); check("preset", d, 32'h7FFF_FFFF);
    do_pulse(1'b1, 3, 4, 4, n, idx);
    rd(2'd0, d); check("wrap", d, 32'h8000_0000);

    @(negedge clk); step_in = 1'b1;
    repeat (3) @(negedge clk);
    write = 1'b1; address = 2'd0; writedata = 32'h1234_5678;
    @(negedge clk);
    check("coinc_pulse", {31'd0, step_pulse}, 32'd1);
    write = 1'b0; step_in = 1'b0;
    repeat (4) @(negedge clk);
    rd(2'd0, d); check("coinc_pos", d, 32'h1234_5678);
    rd(2'd3, d); check("coinc_tot", d, m_tot + 32'd2);

    @(negedge clk); read = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'h0000_AAAA;
    @(negedge clk); read = 1'b0; write = 1'b0;
    check("rw_prewrite", readdata, 32'h1234_5678);
    repeat (3) @(negedge clk);
    check("rd_hold", readdata, 32'h1234_5678);
    rd(2'd0, d); check("rw_postwrite", d, 32'h0000_AAAA);

    rd(2'd1, d);
`ifdef STEP_DIR_DECODER_PERIOD_EN
    do_pulse(1'b1, 3, 4, 92, n, idx);
    do_pulse(1'b1, 3, 4, 92, n, idx);
    rd(2'd1, d); check("period_100", d, 32'd100);
    force dut.r_per_cnt = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.r_per_cnt;
    repeat (2) @(negedge clk);
    rd(2'd1, d); check("period_sat", d, 32'hFFFF_FFFF);
    rd(2'd2, d); check("stall", d & 32'h4, 32'h4);
`else
    check("period_off", d, 32'd0);
`endif

    @(negedge clk); step_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_rdata", readdata, 32'd0);
    check("midrst_pulse", {31'd0, step_pulse}, 32'd0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (step_pulse) seen++;
    end
    check("held_pin_pulses", seen, 32'd0);
    step_in = 1'b0;
    repeat (4) @(negedge clk);
    rd(2'd0, d); check("midrst_pos", d, 32'd0);
    rd(2'd3, d); check("midrst_tot", d, 32'd0);
    do_pulse(1'b1, 3, 4, 4, n, idx);
    check("rearm_pulses", n, 32'd1);
    rd(2'd0, d); check("rearm_pos", d, 32'd1);
    rd(2'd2, d); check("rearm_stat", d, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
